reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001: Parameter XLEN, default 32, data word width in bits.
REQ-002: Parameter AMOUNT, default 16, number of architectural registers, including hardwired register 0.
REQ-003: Parameter ADDRESSLEN, default 4, register address width; the block SHALL require 2**ADDRESSLEN >= AMOUNT.
REQ-004: Parameter NREAD, default 2, number of read ports (1..4).
REQ-005: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006: reset  input  1  synchronous, active-high reset.
REQ-007: rs  input  NREAD*ADDRESSLEN  read addresses; port i occupies bits [i*ADDRESSLEN +: ADDRESSLEN].
REQ-008: rd  input  ADDRESSLEN  write address.
REQ-009: data  input  XLEN  write data.
REQ-010: wEn  input  1  write enable.
REQ-011: r  output  NREAD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN].
REQ-012: busy  output  1  high while the post-reset clear sweep runs; writes are ignored while it is high.

Function
REQ-013: Reads SHALL have 1-cycle latency: r[i] after edge N reflects rs[i] as sampled at edge N.
REQ-014: Address 0 SHALL always read as 0; writes to rd=0 SHALL be discarded.
REQ-015: Addresses >= AMOUNT SHALL read as 0; writes to them SHALL be discarded.
REQ-016: When wEn=1, busy=0, rd!=0, rd<AMOUNT and rs[i]==rd at the same edge, r[i] SHALL return data (write-through bypass), not the old register contents.
REQ-017: The write SHALL commit at the same edge, so any later read of rd returns data.
REQ-018: The FSM SHALL have two states, CLEAR and RUN.
REQ-019: CLEAR SHALL zero one register per cycle using a sweep counter from 1 to AMOUNT-1, then enter RUN; the sweep SHALL take AMOUNT-1 cycles.
REQ-020: busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-021: While busy=1, every r[i] SHALL read 0, regardless of rs.
REQ-022: With wEn=1 and busy=1, no register SHALL change except through the sweep.
REQ-023: All read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-024: With reset=1 at an edge, the FSM SHALL enter CLEAR, the sweep counter SHALL load 1, all r SHALL become 0 and busy SHALL become 1.
REQ-025: Asserting reset during CLEAR SHALL restart the sweep at 1.
REQ-026: Asserting reset during RUN SHALL also restart the sweep at 1, and a write presented at that edge SHALL be discarded.
REQ-027: Register storage SHALL hold no defined value until it has been swept; nothing observable SHALL depend on pre-sweep contents.

Structure
REQ-028: The FSM state encoding (CLEAR=0, RUN=1) and the default parameter values SHALL live in the shared core package/include.
REQ-029: The design SHALL contain one sub-module, reg_file_read_port, instantiated NREAD times via generate. It takes the address, the storage word, the write bypass signals and busy, and produces one registered output.
REQ-030: Storage SHALL be a single array of registers 1..AMOUNT-1, with exactly one write path, muxed between the sweep and the normal write.

Verification
REQ-031: Reset pulse for 1 cycle, AMOUNT=16 -> busy=1 for exactly 15 cycles, then 0; reads of every address return 0 afterwards.
REQ-032: In RUN, write rd=5, data=0xDEADBEEF with rs[0]=5 at the same edge -> r[0]=0xDEADBEEF at the next cycle; rs[1]=5 one cycle later -> 0xDEADBEEF.
REQ-033: Write rd=0, data=0xFFFFFFFF -> reading rs=0 returns 0x00000000; an out-of-range address (AMOUNT=12, rs=13) returns 0.
REQ-034: Reset asserted at sweep counter=7 -> sweep restarts; busy stays high for 15 more cycles; a wEn during busy to rd=3 leaves register 3 reading 0.
REQ-035: NREAD=4, all ports rs=9 after writing 0x12345678 -> all four r slices equal 0x12345678 in the same cycle.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default sizing,
// FSM state encoding and the architectural address-validity helper.
package reg_file_mp_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_AMOUNT     = 16;
    localparam int unsigned DEF_ADDRESSLEN = 4;
    localparam int unsigned DEF_NREAD      = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Register 0 is hardwired and addresses past the last register do not exist.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned amount);
        return (addr != 0) && (addr < amount);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: forces zero while the clear sweep runs and
// forwards the same-edge write so a read never returns stale contents.
module reg_file_read_port #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDRESSLEN = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDRESSLEN-1:0] addr_i,
    input  logic [XLEN-1:0]       word_i,
    input  logic                  byp_en_i,
    input  logic [ADDRESSLEN-1:0] byp_addr_i,
    input  logic [XLEN-1:0]       byp_data_i,
    input  logic                  busy_i,
    output logic [XLEN-1:0]       r_o
);

    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_d;

    always_comb begin
        r_d = word_i;
        if (busy_i) begin
            r_d = '0;
        end else if (byp_en_i && (byp_addr_i == addr_i)) begin
            r_d = byp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired register 0, a post-reset
// clear sweep (busy) and write-through bypass to every read port.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned AMOUNT     = DEF_AMOUNT,
    parameter int unsigned ADDRESSLEN = DEF_ADDRESSLEN,
    parameter int unsigned NREAD      = DEF_NREAD
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREAD*ADDRESSLEN-1:0] rs,
    input  logic [ADDRESSLEN-1:0]       rd,
    input  logic [XLEN-1:0]             data,
    input  logic                        wEn,
    output logic [NREAD*XLEN-1:0]       r,
    output logic                        busy
);

    state_e                state_q;
    logic [ADDRESSLEN-1:0] cnt_q;
    logic                  busy_q;

    logic [XLEN-1:0]       mem_q [1:AMOUNT-1];

    logic                  usr_wr;
    logic                  wr_en;
    logic [ADDRESSLEN-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= ADDRESSLEN'(1);
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (32'(cnt_q) >= AMOUNT - 1) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDRESSLEN'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign usr_wr = wEn && !reset && (state_q == RUN) && addr_in_range(32'(rd), AMOUNT);

    // Single write path: the sweep owns the port while clearing.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_data = data;
        if (!reset && (state_q == CLEAR)) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
        end else if (usr_wr) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 1; k < AMOUNT; k++) begin
            if (wr_en && (32'(wr_addr) == k)) begin
                mem_q[k] <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDRESSLEN-1:0] addr;
        logic [XLEN-1:0]       word;

        assign addr = rs[i*ADDRESSLEN +: ADDRESSLEN];

        // Address 0 and out-of-range addresses fall through to zero.
        always_comb begin
            word = '0;
            for (int unsigned k = 1; k < AMOUNT; k++) begin
                if (32'(addr) == k) begin
                    word = mem_q[k];
                end
            end
        end

        reg_file_read_port #(
            .XLEN       (XLEN),
            .ADDRESSLEN (ADDRESSLEN)
        ) u_port (
            .clk_i      (clk),
            .reset_i    (reset),
            .addr_i     (addr),
            .word_i     (word),
            .byp_en_i   (usr_wr),
            .byp_addr_i (rd),
            .byp_data_i (data),
            .busy_i     (busy_q),
            .r_o        (r[i*XLEN +: XLEN])
        );
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a 16-entry/4-port instance and a
// 12-entry/2-port instance sharing clock and reset.
module tb_reg_file_mp;

    logic         clk = 1'b0;
    logic         reset;

    logic [15:0]  rs_a;
    logic [3:0]   rd_a;
    logic [31:0]  data_a;
    logic         wEn_a;
    logic [127:0] r_a;
    logic         busy_a;

    logic [7:0]   rs_b;
    logic [3:0]   rd_b;
    logic [31:0]  data_b;
    logic         wEn_b;
    logic [63:0]  r_b;
    logic         busy_b;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int unsigned  cnt_a;
    int unsigned  cnt_b;
    int unsigned  guard;

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN       (32),
        .AMOUNT     (16),
        .ADDRESSLEN (4),
        .NREAD      (4)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .rs    (rs_a),
        .rd    (rd_a),
        .data  (data_a),
        .wEn   (wEn_a),
        .r     (r_a),
        .busy  (busy_a)
    );

    reg_file_mp #(
        .XLEN       (32),
        .AMOUNT     (12),
        .ADDRESSLEN (4),
        .NREAD      (2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .rs    (rs_b),
        .rd    (rd_b),
        .data  (data_b),
        .wEn   (wEn_b),
        .r     (r_b),
        .busy  (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        rs_a   = {4{4'd5}};
        rd_a   = 4'd0;
        data_a = 32'h0;
        wEn_a  = 1'b0;
        rs_b   = {2{4'd5}};
        rd_b   = 4'd0;
        data_b = 32'h0;
        wEn_b  = 1'b0;

        tick;
        check("rst_busy_a", 32'(busy_a), 32'd1);
        check("rst_busy_b", 32'(busy_b), 32'd1);
        for (int i = 0; i < 4; i++) check("rst_r_a", r_a[i*32 +: 32], 32'h0);

        // Sweep length: busy counted from the reset edge onward.
        reset = 1'b0;
        cnt_a = 1;
        cnt_b = 1;
        guard = 0;
        while (busy_a && guard < 100) begin
            tick;
            guard++;
            if (busy_a) begin
                cnt_a++;
                for (int i = 0; i < 4; i++) check("busy_r_a", r_a[i*32 +: 32], 32'h0);
            end
            if (busy_b) cnt_b++;
        end
        check("sweep_len_a", cnt_a, 32'd15);
        check("sweep_len_b", cnt_b, 32'd11);

        for (int a = 0; a < 16; a++) begin
            rs_a = {4{4'(a)}};
            tick;
            check("clr_read", r_a[(a % 4)*32 +: 32], 32'h0);
        end

        // Bypass on port 0, committed value on port 1 one cycle later.
        rs_a = {4'd0, 4'd0, 4'd0, 4'd5};
        wEn_a = 1'b1; rd_a = 4'd5; data_a = 32'hDEADBEEF;
        tick;
        check("byp_p0", r_a[31:0], 32'hDEADBEEF);
        check("byp_p1_idle", r_a[63:32], 32'h0);
        wEn_a = 1'b0;
        rs_a = {4'd0, 4'd0, 4'd5, 4'd0};
        tick;
        check("commit_p1", r_a[63:32], 32'hDEADBEEF);
        check("addr0_p0", r_a[31:0], 32'h0);

        // Writes to register 0 are discarded, including the bypass.
        rs_a = {4'd5, 4'd5, 4'd5, 4'd0};
        wEn_a = 1'b1; rd_a = 4'd0; data_a = 32'hFFFFFFFF;
        tick;
        check("wr0_byp", r_a[31:0], 32'h0);
        check("wr0_other", r_a[127:96], 32'hDEADBEEF);
        wEn_a = 1'b0;
        tick;
        check("wr0_read", r_a[31:0], 32'h0);

        rs_a = {4{4'd1}};
        wEn_a = 1'b1; rd_a = 4'd9; data_a = 32'h12345678;
        tick;
        check("wr9_reg1", r_a[31:0], 32'h0);
        wEn_a = 1'b0;
        rs_a = {4{4'd9}};
        tick;
        for (int i = 0; i < 4; i++) check("all9", r_a[i*32 +: 32], 32'h12345678);

        rs_a = {4{4'd10}};
        wEn_a = 1'b1; rd_a = 4'd10; data_a = 32'hA5A50F0F;
        tick;
        for (int i = 0; i < 4; i++) check("byp_all10", r_a[i*32 +: 32], 32'hA5A50F0F);

        // Top register, ports on distinct addresses.
        rs_a = {4'd9, 4'd15, 4'd5, 4'd10};
        wEn_a = 1'b1; rd_a = 4'd15; data_a = 32'h0F0F0001;
        tick;
        check("mix_p0", r_a[31:0],   32'hA5A50F0F);
        check("mix_p1", r_a[63:32],  32'hDEADBEEF);
        check("mix_p2", r_a[95:64],  32'h0F0F0001);
        check("mix_p3", r_a[127:96], 32'h12345678);
        wEn_a = 1'b0;
        tick;
        check("reg15", r_a[95:64], 32'h0F0F0001);

        rs_a = {4'd5, 4'd9, 4'd15, 4'd5};
        wEn_a = 1'b1; rd_a = 4'd5; data_a = 32'h11111111;
        tick;
        check("ovr_byp", r_a[31:0], 32'h11111111);
        check("ovr_p3", r_a[127:96], 32'h11111111);
        wEn_a = 1'b0;
        tick;
        check("ovr_read", r_a[31:0], 32'h11111111);

        // AMOUNT=12 instance: last valid register and out-of-range addresses.
        rs_b = {4'd11, 4'd13};
        wEn_b = 1'b1; rd_b = 4'd11; data_b = 32'hCAFE0011;
        tick;
        check("b_oor_p0", r_b[31:0], 32'h0);
        check("b_byp11", r_b[63:32], 32'hCAFE0011);
        rs_b = {4'd13, 4'd13};
        rd_b = 4'd13; data_b = 32'hBAD0BAD0;
        tick;
        check("b_wr13_p0", r_b[31:0], 32'h0);
        check("b_wr13_p1", r_b[63:32], 32'h0);
        rs_b = {4'd0, 4'd11};
        rd_b = 4'd0; data_b = 32'hFFFFFFFF;
        tick;
        check("b_reg11", r_b[31:0], 32'hCAFE0011);
        check("b_wr0", r_b[63:32], 32'h0);
        wEn_b = 1'b0;
        rs_b = {4'd12, 4'd13};
        tick;
        check("b_rd13", r_b[31:0], 32'h0);
        check("b_rd12", r_b[63:32], 32'h0);

        // Reset from RUN with a write presented, then again mid-sweep at counter 7.
        rs_a = {4{4'd7}};
        wEn_a = 1'b1; rd_a = 4'd7; data_a = 32'h77777777;
        reset = 1'b1;
        tick;
        check("rrun_busy", 32'(busy_a), 32'd1);
        check("rrun_r", r_a[31:0], 32'h0);
        reset = 1'b0;
        wEn_a = 1'b0;
        repeat (6) tick;
        check("cnt7_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        tick;
        check("rclr_busy", 32'(busy_a), 32'd1);
        reset = 1'b0;
        rs_a = {4'd5, 4'd9, 4'd7, 4'd3};
        wEn_a = 1'b1; rd_a = 4'd3; data_a = 32'h33333333;
        cnt_a = 1;
        guard = 0;
        while (busy_a && guard < 100) begin
            tick;
            guard++;
            if (busy_a) begin
                cnt_a++;
                check("rbusy_r3", r_a[31:0], 32'h0);
            end
        end
        check("restart_len", cnt_a, 32'd15);
        wEn_a = 1'b0;
        tick;
        check("post_reg3", r_a[31:0],   32'h0);
        check("post_reg7", r_a[63:32],  32'h0);
        check("post_reg9", r_a[95:64],  32'h0);
        check("post_reg5", r_a[127:96], 32'h0);

        rs_a = {4{4'd3}};
        wEn_a = 1'b1; rd_a = 4'd3; data_a = 32'h33333333;
        tick;
        check("post_wr3", r_a[31:0], 32'h33333333);
        wEn_a = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
